// File: rtl/mshr_pair_alloc_ctrl_if.sv
// Alloc/release handshake bundle between the MSHR pair allocator, the request arbiter
// and the MSHR array release path.
interface mshr_pair_alloc_ctrl_if #(
    parameter int ENTRY_IDX_WIDTH = 4,
    parameter int REL_NUM         = 2
);
    logic                                      mshr_alloc_vld;
    logic [ENTRY_IDX_WIDTH-1:0]                mshr_alloc_idx_1;
    logic [ENTRY_IDX_WIDTH-1:0]                mshr_alloc_idx_2;
    logic                                      mshr_alloc_rdy;
    logic [REL_NUM-1:0]                        v_rel_vld;
    logic [REL_NUM-1:0][ENTRY_IDX_WIDTH-1:0]   v_rel_idx;

    modport master (
        output mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2,
        input  mshr_alloc_rdy, v_rel_vld, v_rel_idx
    );

    modport slave (
        input  mshr_alloc_vld, mshr_alloc_idx_1, mshr_alloc_idx_2,
        output mshr_alloc_rdy, v_rel_vld, v_rel_idx
    );
endinterface

// File: rtl/mshr_pair_alloc_ctrl.sv
// MSHR free-pool owner: offers the two lowest free entries as a registered pair and
// reclaims released entries. Optional pool flush enabled by `define MSHR_ALLOC_FLUSH_EN.
module mshr_pair_alloc_ctrl #(
    parameter int ENTRY_NUM       = 16,
    parameter int ENTRY_IDX_WIDTH = $clog2(ENTRY_NUM),
    parameter int REL_NUM         = 2,
    parameter int CNT_WIDTH       = $clog2(ENTRY_NUM + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef MSHR_ALLOC_FLUSH_EN
    input  logic                         mshr_flush,
`endif
    mshr_pair_alloc_ctrl_if.master       alloc_if,
    output logic [CNT_WIDTH-1:0]         free_cnt,
    output logic                         rel_err
);

    typedef enum logic {
        OFFER_IDLE  = 1'b0,
        OFFER_VALID = 1'b1
    } offer_state_e;

    offer_state_e               state_q, state_d;
    logic [ENTRY_IDX_WIDTH-1:0] idx_1_q, idx_1_d;
    logic [ENTRY_IDX_WIDTH-1:0] idx_2_q, idx_2_d;
    logic [ENTRY_NUM-1:0]       free_map_q, free_map_d;
    logic [CNT_WIDTH-1:0]       free_cnt_q, free_cnt_d;
    logic                       rel_err_q, rel_err_d;

    logic [ENTRY_IDX_WIDTH-1:0] pick_1, pick_2;
    logic [1:0]                 pick_cnt;
    logic                       pair_avail;
    logic                       load_en;
    logic [ENTRY_NUM-1:0]       rel_set;
    logic                       rel_bad;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [ENTRY_NUM-1:0] map);
        logic [CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            cnt = cnt + CNT_WIDTH'(map[i]);
        end
        return cnt;
    endfunction

    // Two lowest set bits of the registered map; releases of this cycle are not yet visible.
    always_comb begin : pick_proc
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pick_1   = '0;
        pick_2   = '0;
        pick_cnt = 2'd0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (free_map_q[i] && pick_cnt == 2'd0) begin
                pick_1   = ENTRY_IDX_WIDTH'(i);
                pick_cnt = 2'd1;
            end else if (free_map_q[i] && pick_cnt == 2'd1) begin
                pick_2   = ENTRY_IDX_WIDTH'(i);
                pick_cnt = 2'd2;
            end
        end
    end

    assign pair_avail = (pick_cnt == 2'd2);
    assign load_en    = (state_q == OFFER_IDLE) || alloc_if.mshr_alloc_rdy;

    // A release is legal only for an entry that is neither free nor sitting in the offer stage.
    always_comb begin : rel_proc
        rel_set = '0;
        rel_bad = 1'b0;
        for (int p = 0; p < REL_NUM; p++) begin
            if (alloc_if.v_rel_vld[p]) begin
                if (free_map_q[alloc_if.v_rel_idx[p]] ||
                    (state_q == OFFER_VALID &&
                     (alloc_if.v_rel_idx[p] == idx_1_q || alloc_if.v_rel_idx[p] == idx_2_q))) begin
                    rel_bad = 1'b1;
                end else begin
                    rel_set[alloc_if.v_rel_idx[p]] = 1'b1;
                end
                for (int q = 0; q < p; q++) begin
                    if (alloc_if.v_rel_vld[q] && alloc_if.v_rel_idx[q] == alloc_if.v_rel_idx[p]) begin
                        rel_bad = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin : next_proc
        state_d    = state_q;
        idx_1_d    = idx_1_q;
        idx_2_d    = idx_2_q;
        free_map_d = free_map_q;
        rel_err_d  = rel_bad;
        if (load_en) begin
            if (pair_avail) begin
                state_d            = OFFER_VALID;
                idx_1_d            = pick_1;
                idx_2_d            = pick_2;
                free_map_d[pick_1] = 1'b0;
                free_map_d[pick_2] = 1'b0;
            end else begin
                state_d = OFFER_IDLE;
            end
        end
        free_map_d = free_map_d | rel_set;
`ifdef MSHR_ALLOC_FLUSH_EN
        if (mshr_flush) begin
            free_map_d = '1;
            state_d    = OFFER_IDLE;
            rel_err_d  = 1'b0;
        end
`endif
        free_cnt_d = popcount(free_map_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OFFER_IDLE;
            idx_1_q    <= '0;
            idx_2_q    <= '0;
            free_map_q <= '1;
            free_cnt_q <= CNT_WIDTH'(ENTRY_NUM);
            rel_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            idx_1_q    <= idx_1_d;
            idx_2_q    <= idx_2_d;
            free_map_q <= free_map_d;
            free_cnt_q <= free_cnt_d;
            rel_err_q  <= rel_err_d;
        end
    end

    assign alloc_if.mshr_alloc_vld   = (state_q == OFFER_VALID);
    assign alloc_if.mshr_alloc_idx_1 = idx_1_q;
    assign alloc_if.mshr_alloc_idx_2 = idx_2_q;
    assign free_cnt                  = free_cnt_q;
    assign rel_err                   = rel_err_q;

endmodule
